sha3_multi_scanner_hub: RTL and testbench
=========================================

# sha3_multi_scanner_hub

Job front end that fans one SHA3 scan job out to `LANES` scanner instances, each of which is a `sha3_scanner_instantiator`-style lane. Each lane gets a disjoint nonce sub-range. The hub collects lane results through per-lane holding registers and a round-robin arbiter into a result FIFO, and reports job completion once every lane has gone idle. It sits between the AXI control logic and the scanner lanes and replaces direct single-scanner wiring.

## Interface
- `LANES`, 4: scanner lanes driven, 1..8.
- `PROPER`, 1: selects blob size; `INPUT_ELEMENTS = PROPER ? 20 : 24` (localparam).
- `NONCE_WORD`, 19: index in `blobby` holding the starting nonce.
- `LANE_SPAN`, 32'h0100_0000: nonce offset between consecutive lanes.
- `FIFO_DEPTH`, 8: result FIFO entries, power of two, ≥2.
- `STOP_ON_FIRST`, 0: 1 = accept only the first result of a job; later captures are discarded without counting.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  job request; accepted only when `idle`.
- `blobby`  in  32×`INPUT_ELEMENTS`  job header, latched on accept.
- `threshold`  in  64  latched on accept and forwarded to all lanes.
- `idle`  out  1  high when no job is in flight.
- `lane_start`  out  `LANES`  one-cycle start strobe per lane.
- `lane_blobby`  out  `LANES`×32×`INPUT_ELEMENTS`  per-lane header.
- `lane_threshold`  out  64  common threshold.
- `lane_idle`  in  `LANES`  lane idle flags.
- `lane_capture`  in  `LANES`  one-cycle "result valid" strobe per lane.
- `lane_hash`  in  `LANES`×25×64  lane hash, valid with the capture strobe.
- `lane_nonce`  in  `LANES`×32  lane nonce, valid with the capture strobe.
- `res_valid`  out  1  FIFO head valid.
- `res_ready`  in  1  pop when `res_valid & res_ready`.
- `res_lane`  out  3  lane index of the FIFO head.
- `res_nonce`  out  32  FIFO head nonce.
- `res_hash`  out  25×64  FIFO head hash.
- `dropped`  out  16  results lost this job; saturates at FFFF.

## Operation
- FSM states: IDLE → LAUNCH → GUARD → RUN → IDLE.
- IDLE, `start` high: latch `blobby` and `threshold`, clear `dropped`, go to LAUNCH.
- LAUNCH (1 cycle):
  - all `lane_start` bits high.
  - `lane_blobby[k]` equals the latched blob, except word `NONCE_WORD` = latched + k·`LANE_SPAN` (mod 2^32).
- GUARD (2 cycles): completion ignored while lanes drop `idle`.
- RUN → IDLE when all three hold in the same cycle:
  - all `lane_idle` are 1;
  - no holding register is occupied;
  - no capture strobe is present this cycle.
- Holding registers, one per lane:
  - A `lane_capture[k]` loads lane k's hash and nonce into holding register k.
  - If register k is already occupied, the new result is dropped and `dropped` increments.
  - Captures are honoured in every state, including IDLE, so late results are not lost.
- Arbiter:
  - Each cycle, if the FIFO is not full, move one occupied holding register into the FIFO.
  - Selection is round-robin, starting after the last granted lane.
  - A register freed this cycle may be reloaded in the same cycle.
- `STOP_ON_FIRST = 1`: after the first FIFO push of a job, all further captures of that job are discarded. These discards are not counted in `dropped`.
- FIFO behaviour:
  - Push and pop in the same cycle while full is legal; occupancy is unchanged.
  - The FIFO is not flushed by `start`; stale results remain poppable.
- `dropped` increments by the number of lanes dropping in that cycle (0..`LANES`).

## Timing
- Reset (`rst` = 0 at a `clk` edge) returns the block to:
  - FSM in IDLE, `idle` = 1;
  - `lane_start` = 0;
  - FIFO empty, `res_valid` = 0;
  - holding registers empty;
  - `dropped` = 0;
  - round-robin pointer = 0.
- Reset mid-job abandons the job. Lanes are not told; their subsequent captures are accepted as in IDLE.
- Accept at cycle t (`start & idle`): `idle` = 0 from t+1; `lane_start` high at t+1 only.
- Lane capture at cycle c: earliest `res_valid` is c+2 (holding register, then FIFO write).
- `res_*` outputs are registered FIFO head values. They are stable while `res_valid & ~res_ready`.
- Completion detected at cycle d: `idle` = 1 at d+1. A new `start` is accepted at d+1.
- `start` while not idle is ignored.

## Test plan
- Nonce split: `LANES` = 4, nonce word = 0x10, `start` → `lane_start` = 4'b1111 for exactly one cycle; nonce words 0x10, 0x0100_0010, 0x0200_0010, 0x0300_0010.
- Wrap: nonce = 0xFF80_0000, `LANES` = 2 → lane 1 nonce = 0x0080_0000.
- Arbitration: lanes 0, 2 and 3 capture in the same cycle → FIFO order is lanes 0, 2, 3 (pointer starts at 0). A repeat burst starts after lane 3. `dropped` = 0.
- Overflow: FIFO_DEPTH = 2, `res_ready` = 0, lane 1 captures 4 times in consecutive cycles → FIFO holds 2 results, holding register 1, `dropped` = 1.
- STOP_ON_FIRST = 1, lanes 2 then 0 capture → exactly one FIFO entry (lane 2), `dropped` = 0. `idle` rises 1 cycle after all lanes are idle.
- Reset: `rst` low during RUN with 3 results queued → next cycle `idle` = 1, `res_valid` = 0, `dropped` = 0.

Source files
------------

// File: rtl/sha3_multi_scanner_hub.sv
// Fans one SHA3 scan job out to LANES scanner lanes with disjoint nonce ranges and
// merges lane results through per-lane holding registers and a round-robin arbiter.
module sha3_multi_scanner_hub #(
    parameter int          LANES          = 4,
    parameter int          PROPER         = 1,
    parameter int          NONCE_WORD     = 19,
    parameter logic [31:0] LANE_SPAN      = 32'h0100_0000,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          STOP_ON_FIRST  = 0,
    localparam int         INPUT_ELEMENTS = (PROPER != 0) ? 20 : 24
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [32*INPUT_ELEMENTS-1:0]        blobby,
    input  logic [63:0]                         threshold,
    output logic                                idle,
    output logic [LANES-1:0]                    lane_start,
    output logic [LANES*32*INPUT_ELEMENTS-1:0]  lane_blobby,
    output logic [63:0]                         lane_threshold,
    input  logic [LANES-1:0]                    lane_idle,
    input  logic [LANES-1:0]                    lane_capture,
    input  logic [LANES*1600-1:0]               lane_hash,
    input  logic [LANES*32-1:0]                 lane_nonce,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [2:0]                          res_lane,
    output logic [31:0]                         res_nonce,
    output logic [1599:0]                       res_hash,
    output logic [15:0]                         dropped
);
    localparam int BLOB_W = 32 * INPUT_ELEMENTS;
    localparam int HASH_W = 1600;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_GUARD, S_RUN} state_t;

    state_t              state, state_next;
    logic                guard_cnt;
    logic [BLOB_W-1:0]   blob_q;
    logic [63:0]         thr_q;
    logic                accept, done;

    logic [LANES-1:0]    hold_valid, hold_valid_next, load, drop;
    logic [HASH_W-1:0]   hold_hash  [LANES];
    logic [31:0]         hold_nonce [LANES];
    logic [2:0]          rr_ptr, grant;
    logic                any_valid, push, pop, can_push, stop_block, job_pushed;
    logic [HASH_W-1:0]   sel_hash;
    logic [31:0]         sel_nonce;
    logic [3:0]          drop_cnt;
    logic [16:0]         drop_sum;

    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [2:0]          fifo_lane  [FIFO_DEPTH];
    logic [31:0]         fifo_nonce [FIFO_DEPTH];
    logic [HASH_W-1:0]   fifo_hash  [FIFO_DEPTH];

    assign accept         = start && (state == S_IDLE);
    assign idle           = (state == S_IDLE);
    assign lane_threshold = thr_q;
    assign done           = (&lane_idle) && !(|hold_valid) && !(|lane_capture);

    always_comb begin
        state_next = state;
        lane_start = '0;
        case (state)
            S_IDLE:   if (start) state_next = S_LAUNCH;
            S_LAUNCH: begin
                lane_start = '1;
                state_next = S_GUARD;
            end
            S_GUARD:  if (guard_cnt) state_next = S_RUN;
            S_RUN:    if (done) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            guard_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            guard_cnt <= (state == S_GUARD) ? ~guard_cnt : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            blob_q <= blobby;
            thr_q  <= threshold;
        end
    end

    // Lane k scans from the latched nonce plus k spans; the add wraps mod 2^32.
    always_comb begin
        lane_blobby = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_blobby[k*BLOB_W +: BLOB_W] = blob_q;
            lane_blobby[k*BLOB_W + NONCE_WORD*32 +: 32] =
                blob_q[NONCE_WORD*32 +: 32] + LANE_SPAN * 32'(k);
        end
    end

    // Round-robin: rr_ptr is the first lane searched; the lowest offset wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            for (int k = 0; k < LANES; k++) begin
                if (hold_valid[k] && (((int'(rr_ptr) + i) % LANES) == k)) begin
                    grant     = 3'(k);
                    any_valid = 1'b1;
                end
            end
        end
    end

    assign pop        = res_valid && res_ready;
    assign can_push   = (count != CW'(FIFO_DEPTH)) || pop;
    assign push       = any_valid && can_push && !((STOP_ON_FIRST != 0) && job_pushed);
    assign stop_block = (STOP_ON_FIRST != 0) && (job_pushed || push);

    always_comb begin
        sel_hash  = '0;
        sel_nonce = '0;
        for (int k = 0; k < LANES; k++) begin
            if (grant == 3'(k)) begin
                sel_hash  = hold_hash[k];
                sel_nonce = hold_nonce[k];
            end
        end
    end

    // A register granted this cycle is free for a capture arriving in the same cycle.
    always_comb begin
        hold_valid_next = hold_valid;
        load            = '0;
        drop            = '0;
        for (int k = 0; k < LANES; k++) begin
            if (stop_block) begin
                hold_valid_next[k] = 1'b0;
            end else if (lane_capture[k]) begin
                if (hold_valid[k] && !(push && (grant == 3'(k)))) begin
                    drop[k] = 1'b1;
                end else begin
                    load[k]            = 1'b1;
                    hold_valid_next[k] = 1'b1;
                end
            end else if (push && (grant == 3'(k))) begin
                hold_valid_next[k] = 1'b0;
            end
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int k = 0; k < LANES; k++) drop_cnt = drop_cnt + 4'(drop[k]);
        drop_sum = {1'b0, dropped} + 17'(drop_cnt);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
            dropped    <= '0;
            job_pushed <= 1'b0;
        end else begin
            hold_valid <= hold_valid_next;
            if (push) rr_ptr <= (grant == 3'(LANES - 1)) ? 3'd0 : grant + 3'd1;
            if (accept)            dropped <= '0;
            else if (drop_sum[16]) dropped <= 16'hFFFF;
            else                   dropped <= drop_sum[15:0];
            if (accept)                              job_pushed <= 1'b0;
            else if (push && (STOP_ON_FIRST != 0))   job_pushed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (load[k]) begin
                hold_hash[k]  <= lane_hash[k*HASH_W +: HASH_W];
                hold_nonce[k] <= lane_nonce[k*32 +: 32];
            end
        end
    end

    // Result port: head is presented while res_valid; it is consumed on a cycle
    // with res_valid & res_ready and stays stable until then.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_lane[wr_ptr]  <= grant;
            fifo_nonce[wr_ptr] <= sel_nonce;
            fifo_hash[wr_ptr]  <= sel_hash;
        end
    end

    assign res_valid = (count != '0);
    assign res_lane  = fifo_lane[rd_ptr];
    assign res_nonce = fifo_nonce[rd_ptr];
    assign res_hash  = fifo_hash[rd_ptr];

endmodule

// File: tb/tb_sha3_multi_scanner_hub.sv
// Bench for sha3_multi_scanner_hub: three instances (4 lanes, 2 lanes with a 2-deep
// FIFO, 4 lanes stop-on-first) driven with directed vectors.
module tb_sha3_multi_scanner_hub;
    localparam int IE = 20;
    localparam int BW = 32 * IE;
    localparam int HW = 1600;
    localparam int EW = 3 + 32 + HW;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // shared lane-side stimulus
    logic [BW-1:0]   blobby;
    logic [63:0]     threshold;
    logic [3:0]      lane_idle;
    logic [4*HW-1:0] lane_hash;
    logic [4*32-1:0] lane_nonce;

    logic a_start, a_idle, a_res_valid, a_ready;
    logic [3:0] a_lane_start, a_cap;
    logic [4*BW-1:0] a_lane_blobby;
    logic [63:0] a_lane_thr;
    logic [2:0] a_res_lane;
    logic [31:0] a_res_nonce;
    logic [HW-1:0] a_res_hash;
    logic [15:0] a_dropped;

    logic b_start, b_idle, b_res_valid, b_ready;
    logic [1:0] b_lane_start, b_cap;
    logic [2*BW-1:0] b_lane_blobby;
    logic [63:0] b_lane_thr;
    logic [2:0] b_res_lane;
    logic [31:0] b_res_nonce;
    logic [HW-1:0] b_res_hash;
    logic [15:0] b_dropped;

    logic c_start, c_idle, c_res_valid, c_ready;
    logic [3:0] c_lane_start, c_cap;
    logic [4*BW-1:0] c_lane_blobby;
    logic [63:0] c_lane_thr;
    logic [2:0] c_res_lane;
    logic [31:0] c_res_nonce;
    logic [HW-1:0] c_res_hash;
    logic [15:0] c_dropped;

    sha3_multi_scanner_hub #(.LANES(4)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .blobby(blobby), .threshold(threshold),
        .idle(a_idle), .lane_start(a_lane_start), .lane_blobby(a_lane_blobby),
        .lane_threshold(a_lane_thr), .lane_idle(lane_idle), .lane_capture(a_cap),
        .lane_hash(lane_hash), .lane_nonce(lane_nonce), .res_valid(a_res_valid),
        .res_ready(a_ready), .res_lane(a_res_lane), .res_nonce(a_res_nonce),
        .res_hash(a_res_hash), .dropped(a_dropped)
    );

    sha3_multi_scanner_hub #(.LANES(2), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .blobby(blobby), .threshold(threshold),
        .idle(b_idle), .lane_start(b_lane_start), .lane_blobby(b_lane_blobby),
        .lane_threshold(b_lane_thr), .lane_idle(lane_idle[1:0]), .lane_capture(b_cap),
        .lane_hash(lane_hash[2*HW-1:0]), .lane_nonce(lane_nonce[63:0]),
        .res_valid(b_res_valid), .res_ready(b_ready), .res_lane(b_res_lane),
        .res_nonce(b_res_nonce), .res_hash(b_res_hash), .dropped(b_dropped)
    );

    sha3_multi_scanner_hub #(.LANES(4), .STOP_ON_FIRST(1)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .blobby(blobby), .threshold(threshold),
        .idle(c_idle), .lane_start(c_lane_start), .lane_blobby(c_lane_blobby),
        .lane_threshold(c_lane_thr), .lane_idle(lane_idle), .lane_capture(c_cap),
        .lane_hash(lane_hash), .lane_nonce(lane_nonce), .res_valid(c_res_valid),
        .res_ready(c_ready), .res_lane(c_res_lane), .res_nonce(c_res_nonce),
        .res_hash(c_res_hash), .dropped(c_dropped)
    );

    // scoreboard state
    logic [EW-1:0] a_exp_q[$];
    logic [EW-1:0] b_exp_q[$];
    logic [EW-1:0] c_exp_q[$];
    string         chk_name_q[$];
    logic [63:0]   chk_act_q[$];
    logic [63:0]   chk_exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] mon_e;
    string         mon_name;
    logic [63:0]   mon_act, mon_exp;
    logic [31:0]   split_exp [4] = '{32'h0000_0010, 32'h0100_0010, 32'h0200_0010, 32'h0300_0010};

    function automatic logic [HW-1:0] mk_hash(input logic [31:0] seed);
        logic [HW-1:0] h;
        for (int i = 0; i < 25; i++) h[i*64 +: 64] = {seed, 32'hC0DE_0000 ^ 32'(i)};
        return h;
    endfunction

    function automatic logic [EW-1:0] ent(input int k, input logic [31:0] nonce);
        return {3'(k), nonce, mk_hash(nonce)};
    endfunction

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_lane(input int k, input logic [31:0] nonce);
        lane_nonce[k*32 +: 32] = nonce;
        lane_hash[k*HW +: HW]  = mk_hash(nonce);
    endtask

    task automatic post(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_name_q.push_back(name);
        chk_act_q.push_back(act);
        chk_exp_q.push_back(exp);
    endtask

    // monitor: drains posted checks and compares every popped result
    always @(negedge clk) begin
        #1;
        while (chk_name_q.size() > 0) begin
            mon_name = chk_name_q.pop_front();
            mon_act  = chk_act_q.pop_front();
            mon_exp  = chk_exp_q.pop_front();
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got %h, want %h", mon_name, mon_act, mon_exp);
            end
        end
        if (a_res_valid && a_ready) begin
            checks++;
            if (a_exp_q.size() == 0) begin
                errors++;
                $display("FAIL a_result: got lane=%0d nonce=%h, want no entry", a_res_lane, a_res_nonce);
            end else begin
                mon_e = a_exp_q.pop_front();
                if ({a_res_lane, a_res_nonce, a_res_hash} !== mon_e) begin
                    errors++;
                    $display("FAIL a_result: got lane=%0d nonce=%h hash_ok=%0d, want lane=%0d nonce=%h",
                             a_res_lane, a_res_nonce, a_res_hash == mon_e[HW-1:0], mon_e[EW-1 -: 3], mon_e[HW +: 32]);
                end
            end
        end
        if (b_res_valid && b_ready) begin
            checks++;
            if (b_exp_q.size() == 0) begin
                errors++;
                $display("FAIL b_result: got lane=%0d nonce=%h, want no entry", b_res_lane, b_res_nonce);
            end else begin
                mon_e = b_exp_q.pop_front();
                if ({b_res_lane, b_res_nonce, b_res_hash} !== mon_e) begin
                    errors++;
                    $display("FAIL b_result: got lane=%0d nonce=%h hash_ok=%0d, want lane=%0d nonce=%h",
                             b_res_lane, b_res_nonce, b_res_hash == mon_e[HW-1:0], mon_e[EW-1 -: 3], mon_e[HW +: 32]);
                end
            end
        end
        if (c_res_valid && c_ready) begin
            checks++;
            if (c_exp_q.size() == 0) begin
                errors++;
                $display("FAIL c_result: got lane=%0d nonce=%h, want no entry", c_res_lane, c_res_nonce);
            end else begin
                mon_e = c_exp_q.pop_front();
                if ({c_res_lane, c_res_nonce, c_res_hash} !== mon_e) begin
                    errors++;
                    $display("FAIL c_result: got lane=%0d nonce=%h hash_ok=%0d, want lane=%0d nonce=%h",
                             c_res_lane, c_res_nonce, c_res_hash == mon_e[HW-1:0], mon_e[EW-1 -: 3], mon_e[HW +: 32]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_cap = '0; b_cap = '0; c_cap = '0;
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        lane_idle = '1; lane_hash = '0; lane_nonce = '0;
        threshold = 64'h0000_00FF_FFFF_FFFF;
        for (int w = 0; w < IE; w++) blobby[w*32 +: 32] = 32'hB000_0000 + 32'(w);
        blobby[19*32 +: 32] = 32'h10;
        tick(2);
        rst = 1'b1;

        // reset state
        post("a_idle_rst", 64'(a_idle), 64'd1);
        post("a_lane_start_rst", 64'(a_lane_start), 64'd0);
        post("a_res_valid_rst", 64'(a_res_valid), 64'd0);
        post("a_dropped_rst", 64'(a_dropped), 64'd0);
        post("b_idle_rst", 64'(b_idle), 64'd1);
        post("c_idle_rst", 64'(c_idle), 64'd1);

        // nonce split on the 4-lane hub
        a_start = 1'b1;
        tick(1);
        a_start = 1'b0;
        lane_idle = 4'b0000;
        blobby[19*32 +: 32] = 32'hDEAD_BEEF;
        post("a_lane_start_launch", 64'(a_lane_start), 64'hF);
        post("a_idle_busy", 64'(a_idle), 64'd0);
        for (int k = 0; k < 4; k++)
            post("a_lane_nonce", 64'(a_lane_blobby[k*BW + 19*32 +: 32]), 64'(split_exp[k]));
        post("a_lane_word0", 64'(a_lane_blobby[3*BW +: 32]), 64'hB000_0000);
        post("a_lane_thr", a_lane_thr, 64'h0000_00FF_FFFF_FFFF);
        tick(1);
        post("a_lane_start_once", 64'(a_lane_start), 64'd0);
        tick(3);

        // arbitration: burst {0,2,3}, lone lane 2, then burst {0,1,3} from pointer 3
        put_lane(0, 32'hA000_0000); put_lane(2, 32'hA000_0002); put_lane(3, 32'hA000_0003);
        a_exp_q.push_back(ent(0, 32'hA000_0000));
        a_exp_q.push_back(ent(2, 32'hA000_0002));
        a_exp_q.push_back(ent(3, 32'hA000_0003));
        a_cap = 4'b1101; tick(1); a_cap = '0; tick(6);
        put_lane(2, 32'hA100_0002);
        a_exp_q.push_back(ent(2, 32'hA100_0002));
        a_cap = 4'b0100; tick(1); a_cap = '0; tick(6);
        put_lane(0, 32'hA200_0000); put_lane(1, 32'hA200_0001); put_lane(3, 32'hA200_0003);
        a_exp_q.push_back(ent(3, 32'hA200_0003));
        a_exp_q.push_back(ent(0, 32'hA200_0000));
        a_exp_q.push_back(ent(1, 32'hA200_0001));
        a_cap = 4'b1011; tick(1); a_cap = '0; tick(6);
        post("a_dropped_arb", 64'(a_dropped), 64'd0);
        post("a_idle_run", 64'(a_idle), 64'd0);
        lane_idle = 4'hF;
        tick(1);
        post("a_idle_done", 64'(a_idle), 64'd1);

        // wrap and overflow on the 2-lane, 2-deep hub
        blobby[19*32 +: 32] = 32'hFF80_0000;
        b_ready = 1'b0;
        b_start = 1'b1;
        lane_idle = 4'b0000;
        tick(1);
        b_start = 1'b0;
        post("b_lane_start_launch", 64'(b_lane_start), 64'h3);
        post("b_nonce_lane0", 64'(b_lane_blobby[19*32 +: 32]), 64'hFF80_0000);
        post("b_nonce_lane1_wrap", 64'(b_lane_blobby[BW + 19*32 +: 32]), 64'h0080_0000);
        post("b_lane_thr", b_lane_thr, 64'h0000_00FF_FFFF_FFFF);
        tick(4);
        for (int n = 0; n < 4; n++) begin
            put_lane(1, 32'hB100_0000 + 32'(n));
            if (n < 3) b_exp_q.push_back(ent(1, 32'hB100_0000 + 32'(n)));
            b_cap = 2'b10;
            tick(1);
        end
        b_cap = '0;
        tick(2);
        post("b_dropped_ovf", 64'(b_dropped), 64'd1);
        post("b_res_valid_full", 64'(b_res_valid), 64'd1);
        b_ready = 1'b1;
        tick(6);
        post("b_res_valid_drained", 64'(b_res_valid), 64'd0);
        lane_idle = 4'hF;
        for (int i = 0; i < 20 && !b_idle; i++) tick(1);
        post("b_idle_end", 64'(b_idle), 64'd1);

        // stop-on-first hub: lane 2 then lane 0 (then lane 3) capture
        c_start = 1'b1;
        lane_idle = 4'b0000;
        tick(1);
        c_start = 1'b0;
        post("c_lane_start_launch", 64'(c_lane_start), 64'hF);
        post("c_nonce_lane3_wrap", 64'(c_lane_blobby[3*BW + 19*32 +: 32]), 64'h0280_0000);
        post("c_lane_thr", c_lane_thr, 64'h0000_00FF_FFFF_FFFF);
        tick(4);
        put_lane(2, 32'hC000_0002);
        c_exp_q.push_back(ent(2, 32'hC000_0002));
        c_cap = 4'b0100; tick(1);
        put_lane(0, 32'hC000_0000);
        c_cap = 4'b0001; tick(1);
        put_lane(3, 32'hC000_0003);
        c_cap = 4'b1000; tick(1);
        c_cap = '0;
        tick(5);
        post("c_dropped", 64'(c_dropped), 64'd0);
        post("c_res_valid_once", 64'(c_res_valid), 64'd0);
        post("c_idle_run", 64'(c_idle), 64'd0);
        lane_idle = 4'hF;
        tick(1);
        post("c_idle_done", 64'(c_idle), 64'd1);

        // reset mid-job with results queued
        a_ready = 1'b0;
        a_start = 1'b1;
        lane_idle = 4'b0000;
        tick(1);
        a_start = 1'b0;
        tick(4);
        for (int k = 0; k < 3; k++) put_lane(k, 32'hD000_0000 + 32'(k));
        a_cap = 4'b0111; tick(1);
        for (int k = 0; k < 3; k++) put_lane(k, 32'hD100_0000 + 32'(k));
        tick(1);
        a_cap = '0;
        tick(6);
        post("a_dropped_pre_rst", 64'(a_dropped), 64'd2);
        post("a_res_valid_pre_rst", 64'(a_res_valid), 64'd1);
        post("a_idle_pre_rst", 64'(a_idle), 64'd0);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        post("a_idle_post_rst", 64'(a_idle), 64'd1);
        post("a_res_valid_post_rst", 64'(a_res_valid), 64'd0);
        post("a_dropped_post_rst", 64'(a_dropped), 64'd0);
        post("a_lane_start_post_rst", 64'(a_lane_start), 64'd0);

        // late captures while idle, arbitration restarting from lane 0
        a_ready = 1'b1;
        put_lane(1, 32'hE000_0001); put_lane(3, 32'hE000_0003);
        a_exp_q.push_back(ent(1, 32'hE000_0001));
        a_exp_q.push_back(ent(3, 32'hE000_0003));
        a_cap = 4'b1010; tick(1); a_cap = '0; tick(6);
        post("a_dropped_idle", 64'(a_dropped), 64'd0);
        lane_idle = 4'hF;

        tick(2);
        post("a_queue_empty", 64'(a_exp_q.size()), 64'd0);
        post("b_queue_empty", 64'(b_exp_q.size()), 64'd0);
        post("c_queue_empty", 64'(c_exp_q.size()), 64'd0);
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
